ifetch: RTL and testbench

- Instruction-fetch unit with a direct-mapped instruction cache. It produces PC / instruction pairs for the decoder and takes redirects from both the decoder and the reorder buffer.
- On a cache miss it fetches the whole word from the memory controller.
- It sits between the memory controller and the decoder, and owns the architectural fetch PC.

---
 rtl/ifetch_pkg.sv | 13 +
 rtl/ifetch_icache_array.sv | 47 ++++
 rtl/ifetch.sv | 131 +++++++++++++
 tb/tb_ifetch.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch shared types
// fetch FSM states and cache geometry
package ifetch_pkg;

  localparam int ICACHE_INDEX_BITS_DEF = 4;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_MISS = 2'd1,
    IF_DROP = 2'd2
  } if_state_e;

endpackage

// File: rtl/ifetch_icache_array.sv
// direct-mapped icache storage
// comb read port, one sync write port
module ifetch_icache_array
  import ifetch_pkg::*;
#(
  parameter int IDX_W = ICACHE_INDEX_BITS_DEF,
  parameter int TAG_W = 30 - ICACHE_INDEX_BITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             hit,
  output logic [31:0]      rd_data,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);

  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0]      data [LINES];

  // valid bits: cleared on reset, set on fill
  always_ff @(posedge clk) begin
    if (rst)
      valid <= '0;
    else if (we)
      valid[wr_idx] <= 1'b1;
  end

  // tag and data payload written on fill
  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

  assign hit     = valid[rd_idx] &&
                   (tags[rd_idx] == rd_tag);
  assign rd_data = data[rd_idx];

endmodule

// File: rtl/ifetch.sv
// instruction fetch unit
// owns fetch PC, icache fill FSM, decoder output
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int ICACHE_INDEX_BITS = ICACHE_INDEX_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        need_inst,
  input  logic        clear_inst,
  input  logic [31:0] if_addr,
  input  logic        rob_clear,
  input  logic [31:0] rob_new_pc,
  output logic [31:0] PC,
  output logic [31:0] inst_in,
  output logic        instcache_ready_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
);

  localparam int IB    = ICACHE_INDEX_BITS;
  localparam int TAG_W = 30 - IB;

  if_state_e   state;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_al;
  logic [31:0] tgt;
  logic [31:0] tgt_al;
  logic        flush;
  logic        consume;
  logic        lookup;
  logic        hit;
  logic [31:0] hit_data;
  logic        fill;

  assign fetch_al = {fetch_pc[31:2], 2'b00};
  assign flush    = rob_clear | clear_inst;
  assign tgt      = rob_clear ? rob_new_pc : if_addr;
  assign tgt_al   = {tgt[31:2], 2'b00};
  assign consume  = instcache_ready_out & ~need_inst;
  assign lookup   = ~instcache_ready_out | consume;
  assign fill     = rdy & mem_done & (state != IF_IDLE);

  ifetch_icache_array #(
    .IDX_W (IB),
    .TAG_W (TAG_W)
  ) u_icache (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (fetch_pc[IB+1:2]),
    .rd_tag  (fetch_pc[31:IB+2]),
    .hit     (hit),
    .rd_data (hit_data),
    .we      (fill),
    .wr_idx  (mem_addr[IB+1:2]),
    .wr_tag  (mem_addr[31:IB+2]),
    .wr_data (mem_data)
  );

  // fetch FSM, fetch PC and registered decoder outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IF_IDLE;
      fetch_pc            <= RESET_PC;
      PC                  <= '0;
      inst_in             <= '0;
      instcache_ready_out <= 1'b0;
      mem_req             <= 1'b0;
      mem_addr            <= '0;
    end else if (rdy) begin
      unique case (state)
        IF_IDLE: begin
          if (flush) begin
            instcache_ready_out <= 1'b0;
            fetch_pc            <= tgt_al;
          end else if (lookup) begin
            if (hit) begin
              PC                  <= fetch_al;
              inst_in             <= hit_data;
              instcache_ready_out <= 1'b1;
              fetch_pc            <= fetch_al + 32'd4;
            end else begin
              state    <= IF_MISS;
              mem_req  <= 1'b1;
              mem_addr <= fetch_al;
              if (consume)
                instcache_ready_out <= 1'b0;
            end
          end
        end
        IF_MISS: begin
          if (mem_done) begin
            mem_req <= 1'b0;
            state   <= IF_IDLE;
            if (flush) begin
              instcache_ready_out <= 1'b0;
              fetch_pc            <= tgt_al;
            end else begin
              PC                  <= mem_addr;
              inst_in             <= mem_data;
              instcache_ready_out <= 1'b1;
              fetch_pc            <= fetch_al + 32'd4;
            end
          end else if (flush) begin
            state               <= IF_DROP;
            instcache_ready_out <= 1'b0;
            fetch_pc            <= tgt_al;
          end
        end
        IF_DROP: begin
          if (mem_done) begin
            mem_req <= 1'b0;
            state   <= IF_IDLE;
          end
          if (flush)
            fetch_pc <= tgt_al;
        end
        default: begin
          state   <= IF_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// ifetch directed testbench
// memory responder with fixed 5-cycle latency
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        need_inst;
  logic        clear_inst;
  logic [31:0] if_addr;
  logic        rob_clear;
  logic [31:0] rob_new_pc;
  logic [31:0] PC;
  logic [31:0] inst_in;
  logic        instcache_ready_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;

  int n_chk  = 0;
  int n_fail = 0;
  int cnt    = 0;

  ifetch dut (
    .clk                 (clk),
    .rst                 (rst),
    .rdy                 (rdy),
    .need_inst           (need_inst),
    .clear_inst          (clear_inst),
    .if_addr             (if_addr),
    .rob_clear           (rob_clear),
    .rob_new_pc          (rob_new_pc),
    .PC                  (PC),
    .inst_in             (inst_in),
    .instcache_ready_out (instcache_ready_out),
    .mem_req             (mem_req),
    .mem_addr            (mem_addr),
    .mem_done            (mem_done),
    .mem_data            (mem_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(
    input logic [31:0] a);
    return (a == 32'h0) ? 32'h13
                        : (32'hA500_0000 ^ a);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // memory controller model
  initial begin
    mem_done = 1'b0;
    mem_data = '0;
    forever begin
      step();
      if (mem_done) begin
        mem_done = 1'b0;
        cnt      = 0;
      end else if (mem_req && rdy && !rst) begin
        cnt++;
        if (cnt == 5) begin
          mem_done = 1'b1;
          mem_data = memval(mem_addr);
        end
      end
    end
  end

  task automatic wait_ready(input logic [31:0] a);
    int n = 0;
    while (!instcache_ready_out && n < 40) begin
      if (mem_req)
        chk("miss_addr", mem_addr, a);
      step();
      n++;
    end
    chk("ready_to", 32'(instcache_ready_out), 32'd1);
    chk("pres_pc", PC, a);
    chk("pres_inst", inst_in, memval(a));
    chk("req_done", 32'(mem_req), 32'd0);
  endtask

  task automatic redir(input logic [31:0] a);
    rob_clear  = 1'b1;
    rob_new_pc = a;
    step();
    rob_clear  = 1'b0;
    chk("redir_rdy", 32'(instcache_ready_out), 32'd0);
  endtask

  task automatic drop_case(input logic [31:0] a,
                           input logic [31:0] b);
    int n = 0;
    redir(a);
    step();
    chk("drop_req", 32'(mem_req), 32'd1);
    chk("drop_addr", mem_addr, a);
    rob_clear  = 1'b1;
    rob_new_pc = b;
    step();
    rob_clear  = 1'b0;
    while (mem_req && n < 40) begin
      chk("drop_hold", mem_addr, a);
      chk("drop_nordy",
          32'(instcache_ready_out), 32'd0);
      step();
      n++;
    end
    chk("drop_to", 32'(mem_req), 32'd0);
    chk("drop_nopres",
        32'(instcache_ready_out), 32'd0);
    step();
    chk("drop_nreq", 32'(mem_req), 32'd1);
    chk("drop_naddr", mem_addr, b);
    wait_ready(b);
  endtask

  initial begin
    rst        = 1'b1;
    rdy        = 1'b1;
    need_inst  = 1'b1;
    clear_inst = 1'b0;
    if_addr    = '0;
    rob_clear  = 1'b0;
    rob_new_pc = '0;
    step();
    step();
    chk("rst_rdy", 32'(instcache_ready_out), 32'd0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_inst", inst_in, 32'h0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    rst = 1'b0;

    // cold start
    wait_ready(32'h0);
    chk("cold_inst", inst_in, 32'h13);

    // consume, miss on 4
    need_inst = 1'b0;
    step();
    need_inst = 1'b1;
    chk("c4_rdy", 32'(instcache_ready_out), 32'd0);
    chk("c4_req", 32'(mem_req), 32'd1);
    chk("c4_addr", mem_addr, 32'h4);
    wait_ready(32'h4);

    // hit latency
    clear_inst = 1'b1;
    if_addr    = 32'h0;
    step();
    clear_inst = 1'b0;
    chk("hl_rdy0", 32'(instcache_ready_out), 32'd0);
    chk("hl_req0", 32'(mem_req), 32'd0);
    step();
    chk("hl_rdy1", 32'(instcache_ready_out), 32'd1);
    chk("hl_pc", PC, 32'h0);
    chk("hl_inst", inst_in, 32'h13);
    chk("hl_req1", 32'(mem_req), 32'd0);

    // backpressure
    repeat (4) begin
      step();
      chk("bp_pc", PC, 32'h0);
      chk("bp_inst", inst_in, 32'h13);
      chk("bp_rdy", 32'(instcache_ready_out), 32'd1);
    end
    need_inst = 1'b0;
    step();
    need_inst = 1'b1;
    chk("bp_pc4", PC, 32'h4);
    chk("bp_inst4", inst_in, 32'hA500_0004);
    chk("bp_rdy4", 32'(instcache_ready_out), 32'd1);
    chk("bp_req4", 32'(mem_req), 32'd0);

    // flush during miss
    drop_case(32'h100, 32'h200);
    drop_case(32'h100, 32'h204);
    redir(32'h100);
    step();
    chk("dfill_rdy", 32'(instcache_ready_out), 32'd1);
    chk("dfill_pc", PC, 32'h100);
    chk("dfill_inst", inst_in, 32'hA500_0100);
    chk("dfill_req", 32'(mem_req), 32'd0);

    // simultaneous redirect
    rob_clear  = 1'b1;
    rob_new_pc = 32'h80;
    clear_inst = 1'b1;
    if_addr    = 32'h40;
    step();
    rob_clear  = 1'b0;
    clear_inst = 1'b0;
    chk("sim_rdy", 32'(instcache_ready_out), 32'd0);
    step();
    chk("sim_req", 32'(mem_req), 32'd1);
    chk("sim_addr", mem_addr, 32'h80);
    wait_ready(32'h80);

    // alias on index 0
    redir(32'h0);
    step();
    chk("al0_req", 32'(mem_req), 32'd1);
    chk("al0_addr", mem_addr, 32'h0);
    wait_ready(32'h0);
    redir(32'h40);
    step();
    chk("al40_req", 32'(mem_req), 32'd1);
    chk("al40_addr", mem_addr, 32'h40);
    wait_ready(32'h40);
    redir(32'h0);
    step();
    chk("alb_req", 32'(mem_req), 32'd1);
    chk("alb_addr", mem_addr, 32'h0);
    wait_ready(32'h0);

    // rdy low freezes consume
    rdy       = 1'b0;
    need_inst = 1'b0;
    repeat (3) begin
      step();
      chk("frz_rdy", 32'(instcache_ready_out), 32'd1);
      chk("frz_pc", PC, 32'h0);
      chk("frz_req", 32'(mem_req), 32'd0);
    end
    need_inst = 1'b1;
    rdy       = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
